cond_logic: RTL and testbench

COND_LOGIC -- requirements
Module: cond_logic

---
 rtl/cond_logic.sv | 96 +++++++++
 tb/tb_cond_logic.sv | 209 ++++++++++++++++++++
 2 files changed

// File: rtl/cond_logic.sv
// Conditional-execution unit: evaluates the condition field against the architectural
// flags, gates the write enables, and squashes the instruction after a taken branch.
module cond_logic (
    input  logic       clk,
    input  logic       reset,
    input  logic       InstrValid,
    input  logic [3:0] Cond,
    input  logic [3:0] ALUFlags,
    input  logic [1:0] FlagW,
    input  logic       PCS,
    input  logic       RegW,
    input  logic       MemW,
    input  logic       NoWrite,
    output logic       PCSrc,
    output logic       RegWrite,
    output logic       MemWrite,
    output logic       CondEx,
    output logic [3:0] Flags,
    output logic       Flush
);

    typedef enum logic {
        IDLE   = 1'b0,
        SQUASH = 1'b1
    } state_t;

    state_t     state_q, state_d;
    logic [3:0] flags_q, flags_d;
    logic       cond_true;

    // Flags are packed {N,Z,C,V}; code 1111 is treated as "never".
    function automatic logic eval_cond(input logic [3:0] c, input logic [3:0] f);
        logic n, z, cy, v;
        logic r;
        n  = f[3];
        z  = f[2];
        cy = f[1];
        v  = f[0];
        case (c)
            4'b0000: r = z;
            4'b0001: r = ~z;
            4'b0010: r = cy;
            4'b0011: r = ~cy;
            4'b0100: r = n;
            4'b0101: r = ~n;
            4'b0110: r = v;
            4'b0111: r = ~v;
            4'b1000: r = cy & ~z;
            4'b1001: r = ~cy | z;
            4'b1010: r = (n == v);
            4'b1011: r = (n != v);
            4'b1100: r = ~z & (n == v);
            4'b1101: r = z | (n != v);
            4'b1110: r = 1'b1;
            default: r = 1'b0;
        endcase
        return r;
    endfunction

    always_comb begin
        Flush     = (state_q == SQUASH);
        Flags     = flags_q;
        cond_true = eval_cond(Cond, flags_q);
        CondEx    = InstrValid & ~Flush & ~reset & cond_true;
        // AND gating keeps unknown decoder requests off the outputs when CondEx=0.
        PCSrc     = PCS & CondEx;
        RegWrite  = RegW & CondEx & ~NoWrite;
        MemWrite  = MemW & CondEx;
    end

    always_comb begin
        flags_d = flags_q;
        if (CondEx && FlagW[1]) flags_d[3:2] = ALUFlags[3:2];
        if (CondEx && FlagW[0]) flags_d[1:0] = ALUFlags[1:0];
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (PCSrc) state_d = SQUASH;
            SQUASH:  state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            flags_q <= 4'b0000;
        end else begin
            state_q <= state_d;
            flags_q <= flags_d;
        end
    end

endmodule

// File: tb/tb_cond_logic.sv
// Scoreboard bench for cond_logic: a driver pushes model-predicted outputs per cycle,
// a monitor pops and compares them; directed scenarios add constant checks.
module tb_cond_logic;

    logic       clk;
    logic       reset;
    logic       InstrValid;
    logic [3:0] Cond;
    logic [3:0] ALUFlags;
    logic [1:0] FlagW;
    logic       PCS, RegW, MemW, NoWrite;
    logic       PCSrc, RegWrite, MemWrite, CondEx;
    logic [3:0] Flags;
    logic       Flush;

    cond_logic dut (
        .clk(clk), .reset(reset), .InstrValid(InstrValid), .Cond(Cond),
        .ALUFlags(ALUFlags), .FlagW(FlagW), .PCS(PCS), .RegW(RegW), .MemW(MemW),
        .NoWrite(NoWrite), .PCSrc(PCSrc), .RegWrite(RegWrite), .MemWrite(MemWrite),
        .CondEx(CondEx), .Flags(Flags), .Flush(Flush)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        bit       condex;
        bit       pcsrc;
        bit       regwrite;
        bit       memwrite;
        bit [3:0] flags;
        bit       flush;
    } exp_t;

    exp_t exp_q[$];
    int   n_checks = 0;
    int   n_fail   = 0;

    // reference state
    bit [3:0] m_flags  = 4'b0000;
    bit       m_squash = 1'b0;
    // inputs applied in the current cycle, consumed at the next edge
    bit       p_rst    = 1'b1;
    bit       p_condex = 1'b0;
    bit       p_pcsrc  = 1'b0;
    bit [1:0] p_flagw  = 2'b00;
    bit [3:0] p_aluf   = 4'b0000;

    // Conditions come in pairs: even code tests a predicate, odd code is its inverse.
    function automatic bit ref_cond(bit [3:0] c, bit [3:0] f);
        bit n, z, cy, v, base;
        n = f[3]; z = f[2]; cy = f[1]; v = f[0];
        case (c[3:1])
            3'd0: base = z;
            3'd1: base = cy;
            3'd2: base = n;
            3'd3: base = v;
            3'd4: base = cy && !z;
            3'd5: base = (n == v);
            3'd6: base = !z && (n == v);
            default: base = 1'b1;
        endcase
        return base ^ c[0];
    endfunction

    task automatic chk(string name, logic [3:0] act, logic [3:0] req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %b, required %b at %0t", name, act, req, $time);
        end
    endtask

    // One instruction per cycle: advance the model over the previous edge, drive, predict.
    task automatic step(bit rst, bit valid, bit [3:0] c, bit [3:0] aluf, bit [1:0] fw,
                        bit pcs, bit regw, bit memw, bit nowrite);
        exp_t e;
        @(posedge clk);
        if (p_rst) begin
            m_flags  = 4'b0000;
            m_squash = 1'b0;
        end else begin
            if (p_condex && p_flagw[1]) m_flags[3:2] = p_aluf[3:2];
            if (p_condex && p_flagw[0]) m_flags[1:0] = p_aluf[1:0];
            m_squash = m_squash ? 1'b0 : p_pcsrc;
        end
        #1;
        reset = rst; InstrValid = valid; Cond = c; ALUFlags = aluf; FlagW = fw;
        PCS = pcs; RegW = regw; MemW = memw; NoWrite = nowrite;
        e.flush    = m_squash;
        e.flags    = m_flags;
        e.condex   = valid && !m_squash && !rst && ref_cond(c, m_flags);
        e.pcsrc    = pcs && e.condex;
        e.regwrite = regw && e.condex && !nowrite;
        e.memwrite = memw && e.condex;
        exp_q.push_back(e);
        p_rst = rst; p_condex = e.condex; p_pcsrc = e.pcsrc; p_flagw = fw; p_aluf = aluf;
        #2;
    endtask

    task automatic idle();
        step(1'b0, 1'b0, 4'hE, 4'h0, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic do_reset();
        step(1'b1, 1'b0, 4'hE, 4'h0, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            exp_t e;
            e = exp_q.pop_front();
            chk("sb_condex",   {3'b0, CondEx},   {3'b0, e.condex});
            chk("sb_pcsrc",    {3'b0, PCSrc},    {3'b0, e.pcsrc});
            chk("sb_regwrite", {3'b0, RegWrite}, {3'b0, e.regwrite});
            chk("sb_memwrite", {3'b0, MemWrite}, {3'b0, e.memwrite});
            chk("sb_flags",    Flags,            e.flags);
            chk("sb_flush",    {3'b0, Flush},    {3'b0, e.flush});
        end
    end

    initial begin
        reset = 1'b1; InstrValid = 1'b0; Cond = 4'hE; ALUFlags = 4'h0; FlagW = 2'b00;
        PCS = 1'b0; RegW = 1'b0; MemW = 1'b0; NoWrite = 1'b0;

        // reset state, reset with a live instruction presented
        do_reset();
        step(1'b1, 1'b1, 4'hE, 4'hF, 2'b11, 1'b1, 1'b1, 1'b1, 1'b0);
        chk("rst_condex", {3'b0, CondEx}, 4'd0);
        chk("rst_pcsrc",  {3'b0, PCSrc},  4'd0);

        // AL register write right after reset
        step(1'b0, 1'b1, 4'hE, 4'h0, 2'b00, 1'b0, 1'b1, 1'b0, 1'b0);
        chk("al_regwrite", {3'b0, RegWrite}, 4'd1);
        chk("al_memwrite", {3'b0, MemWrite}, 4'd0);
        chk("al_pcsrc",    {3'b0, PCSrc},    4'd0);
        chk("al_flags",    Flags,            4'b0000);

        // CMP then BEQ
        step(1'b0, 1'b1, 4'hE, 4'b0100, 2'b11, 1'b0, 1'b1, 1'b0, 1'b1);
        chk("cmp_regwrite", {3'b0, RegWrite}, 4'd0);
        step(1'b0, 1'b1, 4'h0, 4'h0, 2'b00, 1'b1, 1'b0, 1'b0, 1'b0);
        chk("beq_flags", Flags,           4'b0100);
        chk("beq_pcsrc", {3'b0, PCSrc},   4'd1);
        idle();
        chk("beq_flush1", {3'b0, Flush}, 4'd1);
        idle();
        chk("beq_flush0", {3'b0, Flush}, 4'd0);

        // NZ-only flag write
        do_reset();
        step(1'b0, 1'b1, 4'hE, 4'b1111, 2'b10, 1'b0, 1'b0, 1'b0, 1'b0);
        idle();
        chk("nz_only_flags", Flags, 4'b1100);

        // taken branch followed by a store
        step(1'b0, 1'b1, 4'hE, 4'h0, 2'b00, 1'b1, 1'b0, 1'b0, 1'b0);
        step(1'b0, 1'b1, 4'hE, 4'h0, 2'b00, 1'b0, 1'b0, 1'b1, 1'b0);
        chk("st_flush1",   {3'b0, Flush},    4'd1);
        chk("st_memwrite", {3'b0, MemWrite}, 4'd0);
        idle();
        chk("st_flush0", {3'b0, Flush}, 4'd0);

        // back-to-back branches: the second must not re-arm the squash
        step(1'b0, 1'b1, 4'hE, 4'h0, 2'b00, 1'b1, 1'b0, 1'b0, 1'b0);
        step(1'b0, 1'b1, 4'hE, 4'hF, 2'b11, 1'b1, 1'b0, 1'b0, 1'b0);
        chk("b2b_flush1", {3'b0, Flush}, 4'd1);
        idle();
        chk("b2b_flush0", {3'b0, Flush}, 4'd0);
        chk("b2b_flags",  Flags,         4'b1100);

        // condition sweep; flags loaded through an AL flag-setting instruction
        for (int f = 0; f < 16; f++) begin
            do_reset();
            step(1'b0, 1'b1, 4'hE, f[3:0], 2'b11, 1'b0, 1'b0, 1'b0, 1'b0);
            for (int c = 0; c < 16; c++)
                step(1'b0, 1'b1, c[3:0], 4'h0, 2'b00, 1'b0, 1'b1, 1'b1, 1'b0);
        end
        step(1'b0, 1'b1, 4'hF, 4'h0, 2'b00, 1'b1, 1'b1, 1'b1, 1'b0);
        chk("nv_condex", {3'b0, CondEx}, 4'd0);

        // reset in the cycle after a taken branch
        step(1'b0, 1'b1, 4'hE, 4'h0, 2'b00, 1'b1, 1'b0, 1'b0, 1'b0);
        step(1'b1, 1'b1, 4'hE, 4'hF, 2'b11, 1'b1, 1'b1, 1'b1, 1'b0);
        step(1'b0, 1'b0, 4'hE, 4'h0, 2'b00, 1'b1, 1'b1, 1'b1, 1'b0);
        chk("rstbr_flush", {3'b0, Flush}, 4'd0);
        chk("rstbr_flags", Flags,         4'b0000);
        chk("rstbr_outs",  {CondEx, PCSrc, RegWrite, MemWrite}, 4'b0000);
        step(1'b0, 1'b1, 4'h0, 4'h0, 2'b00, 1'b0, 1'b1, 1'b0, 1'b0);
        chk("post_rst_eq", {3'b0, CondEx}, 4'd0);
        step(1'b0, 1'b1, 4'h1, 4'h0, 2'b00, 1'b0, 1'b1, 1'b0, 1'b0);
        chk("post_rst_ne", {3'b0, CondEx}, 4'd1);

        // randomized traffic
        for (int i = 0; i < 600; i++) begin
            step(($urandom_range(0, 29) == 0), ($urandom_range(0, 7) != 0),
                 4'($urandom), 4'($urandom), 2'($urandom),
                 ($urandom_range(0, 3) == 0), 1'($urandom), 1'($urandom), 1'($urandom));
        end

        idle();
        @(posedge clk);
        #6;
        chk("sb_drained", 4'(exp_q.size()), 4'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
